// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_t;

endpackage

// File: rtl/arb_latency_timer.sv
// Loadable down-counter that flags the last cycle of an SRAM access window.
// Latency: done asserts LATENCY cycles after load (in the last decrement cycle).
// Backpressure: none; dec simply holds while low.
module arb_latency_timer #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt;

  // Load the full window on grant, count down once per access cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LATENCY);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CW'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port SRAM between IF fetches and MEM loads/stores.
// Latency: request seen in IDLE cycle t -> ready pulse in cycle t+MEM_LATENCY+1.
// Backpressure: requester holds req until its one-cycle ready; stall = req & ~ready.
module unified_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int MEM_LATENCY    = 1,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int SW = $clog2(MAX_MEM_STREAK + 1);

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic              we_q;
  logic [SW-1:0]     streak_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              mem_any;
  logic              if_wins;
  logic              grant;
  logic              lat_done;

  assign mem_any = mem_rd_req | mem_wr_req;
  // IF only beats a pending MEM request once MEM has used up its streak.
  assign if_wins = if_req & (~mem_any | (streak_q == SW'(MAX_MEM_STREAK)));
  assign grant   = (state_q == IDLE) & (if_req | mem_any);

  arb_latency_timer #(
    .LATENCY(MEM_LATENCY)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (grant),
    .dec  (state_q == ACCESS),
    .done (lat_done)
  );

  // State register; async reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: IDLE -> ACCESS on grant, ACCESS -> RESP when window ends, RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  if (lat_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's request so later input changes cannot disturb the access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= if_wins ? OWN_IF : OWN_MEM;
      we_q    <= ~if_wins & mem_wr_req;
      addr_q  <= if_wins ? if_addr : mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // Count MEM grants taken while IF was waiting; any other grant resets it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else if (grant) begin
      if (if_wins || !if_req) streak_q <= '0;
      else if (streak_q != SW'(MAX_MEM_STREAK)) streak_q <= streak_q + 1'b1;
    end
  end

  // Capture read data on the last access cycle into the owner's register only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else if ((state_q == ACCESS) && lat_done && !we_q) begin
      if (owner_q == OWN_IF) if_rdata_q  <= sram_rdata;
      else                   mem_rdata_q <= sram_rdata;
    end
  end

  assign sram_en    = (state_q == ACCESS);
  assign sram_we    = sram_en & we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign if_ready   = (state_q == RESP) & (owner_q == OWN_IF);
  assign mem_ready  = (state_q == RESP) & (owner_q == OWN_MEM);
  assign if_stall   = rst & if_req & ~if_ready;
  assign mem_stall  = rst & mem_any & ~mem_ready;

endmodule
